// File: rtl/bus_matrix_pkg.sv
// rtl/bus_matrix_pkg.sv - shared bus matrix types: region attributes, firewall verdicts and states
package bus_matrix_pkg;

  localparam int unsigned FW_ADDR_W = 32;
  localparam int unsigned FW_CNT_W  = 16;

  typedef struct packed {
    logic [FW_ADDR_W-1:0] start_addr;
    logic [FW_ADDR_W-1:0] end_addr;
    logic                 secure_only;
    logic                 read_only;
  } region_attr_t;

  typedef enum logic [1:0] {
    VIOL_NONE      = 2'd0,
    VIOL_NO_REGION = 2'd1,
    VIOL_SECURE    = 2'd2,
    VIOL_READONLY  = 2'd3
  } fw_viol_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2,
    ST_DENY = 2'd3
  } fw_state_e;

  // Both bounds inclusive.
  function automatic logic in_region(input region_attr_t r, input logic [FW_ADDR_W-1:0] adr);
    return (adr >= r.start_addr) && (adr <= r.end_addr);
  endfunction

endpackage

// File: rtl/bus_matrix_region_check.sv
// rtl/bus_matrix_region_check.sv - combinational region lookup returning hit index and access verdict
module bus_matrix_region_check
  import bus_matrix_pkg::*;
#(
  parameter int                             NUM_REGIONS = 4,
  parameter region_attr_t [NUM_REGIONS-1:0] REGIONS     = '0
) (
  input  logic [FW_ADDR_W-1:0] adr_i,
  input  logic                 we_i,
  input  logic                 secure_i,
  output logic                 hit_o,
  output logic [3:0]           hit_idx_o,
  output fw_viol_e             viol_o
);

  // Scan from the top down so the lowest-index hit is the last one written.
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = 4'd0;
    viol_o    = VIOL_NO_REGION;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (in_region(REGIONS[i], adr_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = 4'(i);
        if (REGIONS[i].secure_only && !secure_i) begin
          viol_o = VIOL_SECURE;
        end else if (REGIONS[i].read_only && we_i) begin
          viol_o = VIOL_READONLY;
        end else begin
          viol_o = VIOL_NONE;
        end
      end
    end
  end

endmodule

// File: rtl/bus_matrix_wb_firewall.sv
// rtl/bus_matrix_wb_firewall.sv - Wishbone slave-side region firewall with downstream timeout;
// optional violation log enabled by BUS_MATRIX_FW_VIOLATION_LOG_EN
module bus_matrix_wb_firewall
  import bus_matrix_pkg::*;
#(
  parameter int                             NUM_REGIONS    = 4,
  parameter region_attr_t [NUM_REGIONS-1:0] REGIONS        = '0,
  parameter int                             TIMEOUT_CYCLES = 255,
  parameter int                             DATA_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_cyc_i,
  input  logic                    s_stb_i,
  input  logic                    s_we_i,
  input  logic [31:0]             s_adr_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic [DATA_WIDTH/8-1:0] s_sel_i,
  input  logic                    s_secure_i,
  output logic                    s_ack_o,
  output logic                    s_err_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic                    m_cyc_o,
  output logic                    m_stb_o,
  output logic                    m_we_o,
  output logic [31:0]             m_adr_o,
  output logic [DATA_WIDTH-1:0]   m_dat_o,
  output logic [DATA_WIDTH/8-1:0] m_sel_o,
  input  logic [DATA_WIDTH-1:0]   m_dat_i,
  input  logic                    m_ack_i,
  input  logic                    m_err_i,
  output logic                    viol_valid_o,
  output logic [31:0]             viol_addr_o,
  output logic [1:0]              viol_code_o,
  output logic [15:0]             viol_count_o,
  input  logic                    viol_clr_i
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam logic [FW_CNT_W-1:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic       rc_hit;
  logic [3:0] rc_hit_idx;
  fw_viol_e   rc_viol;

  bus_matrix_region_check #(
    .NUM_REGIONS(NUM_REGIONS),
    .REGIONS    (REGIONS)
  ) u_region_check (
    .adr_i    (s_adr_i),
    .we_i     (s_we_i),
    .secure_i (s_secure_i),
    .hit_o    (rc_hit),
    .hit_idx_o(rc_hit_idx),
    .viol_o   (rc_viol)
  );

  logic unused_rc;
  assign unused_rc = rc_hit ^ (^rc_hit_idx);

  fw_state_e             state_q, state_d;
  logic [FW_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  m_cyc_q, m_cyc_d;
  logic                  m_we_q, m_we_d;
  logic [31:0]           m_adr_q, m_adr_d;
  logic [DATA_WIDTH-1:0] m_dat_q, m_dat_d;
  logic [SEL_W-1:0]      m_sel_q, m_sel_d;
  logic                  s_ack_q, s_ack_d;
  logic                  s_err_q, s_err_d;
  logic [DATA_WIDTH-1:0] s_dat_q, s_dat_d;
  logic                  deny_entry;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    m_cyc_d    = m_cyc_q;
    m_we_d     = m_we_q;
    m_adr_d    = m_adr_q;
    m_dat_d    = m_dat_q;
    m_sel_d    = m_sel_q;
    s_ack_d    = 1'b0;
    s_err_d    = 1'b0;
    s_dat_d    = s_dat_q;
    deny_entry = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          if (rc_viol != VIOL_NONE) begin
            state_d    = ST_DENY;
            s_err_d    = 1'b1;
            deny_entry = 1'b1;
          end else begin
            state_d = ST_FWD;
            m_cyc_d = 1'b1;
            m_we_d  = s_we_i;
            m_adr_d = s_adr_i;
            m_dat_d = s_dat_i;
            m_sel_d = s_sel_i;
            cnt_d   = '0;
          end
        end
      end
      ST_FWD: begin
        // An abort outranks a same-cycle slave response, which is dropped.
        if (!s_cyc_i) begin
          state_d = ST_IDLE;
          m_cyc_d = 1'b0;
        end else if (m_ack_i || m_err_i) begin
          state_d = ST_RESP;
          m_cyc_d = 1'b0;
          s_dat_d = m_dat_i;
          s_err_d = m_err_i;
          s_ack_d = !m_err_i;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_RESP;
          m_cyc_d = 1'b0;
          s_err_d = 1'b1;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      m_cyc_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_adr_q <= '0;
      m_dat_q <= '0;
      m_sel_q <= '0;
      s_ack_q <= 1'b0;
      s_err_q <= 1'b0;
      s_dat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_cyc_q <= m_cyc_d;
      m_we_q  <= m_we_d;
      m_adr_q <= m_adr_d;
      m_dat_q <= m_dat_d;
      m_sel_q <= m_sel_d;
      s_ack_q <= s_ack_d;
      s_err_q <= s_err_d;
      s_dat_q <= s_dat_d;
    end
  end

  assign s_ack_o = s_ack_q;
  assign s_err_o = s_err_q;
  assign s_dat_o = s_dat_q;
  assign m_cyc_o = m_cyc_q;
  assign m_stb_o = m_cyc_q;
  assign m_we_o  = m_we_q;
  assign m_adr_o = m_adr_q;
  assign m_dat_o = m_dat_q;
  assign m_sel_o = m_sel_q;

`ifdef BUS_MATRIX_FW_VIOLATION_LOG_EN
  logic        vld_q, vld_d;
  logic [31:0] vaddr_q, vaddr_d;
  fw_viol_e    vcode_q, vcode_d;
  logic [15:0] vcnt_q, vcnt_d;

  // A clear wins over a same-cycle capture, but that violation still counts.
  always_comb begin
    vld_d   = vld_q;
    vaddr_d = vaddr_q;
    vcode_d = vcode_q;
    vcnt_d  = vcnt_q;
    if (viol_clr_i) begin
      vld_d   = 1'b0;
      vaddr_d = '0;
      vcode_d = VIOL_NONE;
      vcnt_d  = '0;
    end
    if (deny_entry) begin
      if (viol_clr_i) begin
        vcnt_d = 16'd1;
      end else if (vcnt_q != 16'hFFFF) begin
        vcnt_d = vcnt_q + 16'd1;
      end
      if (!viol_clr_i && !vld_q) begin
        vld_d   = 1'b1;
        vaddr_d = s_adr_i;
        vcode_d = rc_viol;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      vaddr_q <= '0;
      vcode_q <= VIOL_NONE;
      vcnt_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      vaddr_q <= vaddr_d;
      vcode_q <= vcode_d;
      vcnt_q  <= vcnt_d;
    end
  end

  assign viol_valid_o = vld_q;
  assign viol_addr_o  = vaddr_q;
  assign viol_code_o  = vcode_q;
  assign viol_count_o = vcnt_q;
`else
  logic unused_log;
  assign unused_log   = viol_clr_i ^ deny_entry;
  assign viol_valid_o = 1'b0;
  assign viol_addr_o  = '0;
  assign viol_code_o  = '0;
  assign viol_count_o = '0;
`endif

endmodule
